// File: rtl/dct_pkg.sv
// Shared defaults for the streaming 2-D DCT controller and its transpose banks.
// Bank-select encodings name the two halves of the ping-pong buffer.
package dct_pkg;
    localparam int N_DEF     = 8;
    localparam int IN_W_DEF  = 8;
    localparam int MID_W_DEF = 8;
    localparam int OUT_W_DEF = 12;
    localparam int CNT_W_DEF = 15;
    localparam int IDX_W_DEF = $clog2(N_DEF);

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;
endpackage

// File: rtl/tpose_bank.sv
// One half of the transpose buffer: NxN register array written a row at a time
// and read a column at a time without a clock edge in between.
module tpose_bank
    import dct_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int MID_W = MID_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_row,
    input  logic [N*MID_W-1:0]   wr_data,
    input  logic [IDX_W-1:0]     rd_col,
    output logic [N*MID_W-1:0]   rd_data
);
    // Contents are deliberately not reset; full flags in the top gate every read.
    logic [MID_W-1:0] mem [N][N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_row][c] <= wr_data[c*MID_W +: MID_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < N; r++) begin
            rd_data[r*MID_W +: MID_W] = mem[r][rd_col];
        end
    end
endmodule

// File: rtl/dct2d_stream.sv
// Streaming NxN 2-D DCT controller: rows go through the row kernel into a
// ping-pong transpose buffer, columns come back out through the column kernel.
module dct2d_stream
    import dct_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int MID_W = MID_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*IN_W-1:0]    in_data,
    output logic [N*IN_W-1:0]    k1_in,
    input  logic [N*MID_W-1:0]   k1_out,
    output logic [N*MID_W-1:0]   k2_in,
    output logic                 k2_dc,
    input  logic [N*OUT_W-1:0]   k2_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*OUT_W-1:0]   out_data,
    output logic                 out_sof,
    output logic                 out_eob,
    output logic [CNT_W-1:0]     blk_in_cnt,
    output logic [CNT_W-1:0]     blk_out_cnt
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic               wr_bank, rd_bank;
    logic [1:0]         full, full_nxt;
    logic [IDX_W-1:0]   wr_row, rd_col;
    logic               in_hs, wr_last, load, rd_last, out_hs;
    logic [N*MID_W-1:0] col_a, col_b;

    assign in_ready = !full[wr_bank];
    assign in_hs    = in_valid & in_ready;
    assign wr_last  = in_hs & (wr_row == LAST);
    assign load     = full[rd_bank] & (!out_valid | out_ready);
    assign rd_last  = load & (rd_col == LAST);
    assign out_hs   = out_valid & out_ready;

    assign k1_in = in_data;
    assign k2_in = (rd_bank == BANK_B) ? col_b : col_a;
    // Gated by full so the column kernel never sees a DC strobe on an empty bank.
    assign k2_dc = full[rd_bank] & (rd_col == '0);

    tpose_bank #(.N(N), .MID_W(MID_W), .IDX_W(IDX_W)) u_bank_a (
        .clk     (clk),
        .wr_en   (in_hs & (wr_bank == BANK_A)),
        .wr_row  (wr_row),
        .wr_data (k1_out),
        .rd_col  (rd_col),
        .rd_data (col_a)
    );

    tpose_bank #(.N(N), .MID_W(MID_W), .IDX_W(IDX_W)) u_bank_b (
        .clk     (clk),
        .wr_en   (in_hs & (wr_bank == BANK_B)),
        .wr_row  (wr_row),
        .wr_data (k1_out),
        .rd_col  (rd_col),
        .rd_data (col_b)
    );

    // Set and clear can coincide; they always target different banks.
    always_comb begin
        full_nxt = full;
        if (wr_last) full_nxt[wr_bank] = 1'b1;
        if (rd_last) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_bank     <= BANK_A;
            rd_bank     <= BANK_A;
            full        <= '0;
            wr_row      <= '0;
            rd_col      <= '0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eob     <= 1'b0;
            out_data    <= '0;
            blk_in_cnt  <= '0;
            blk_out_cnt <= '0;
        end else begin
            full <= full_nxt;
            if (in_hs) begin
                if (wr_last) begin
                    wr_row     <= '0;
                    wr_bank    <= ~wr_bank;
                    blk_in_cnt <= blk_in_cnt + 1'b1;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            if (load) begin
                out_data  <= k2_out;
                out_valid <= 1'b1;
                out_sof   <= (rd_col == '0);
                out_eob   <= (rd_col == LAST);
                if (rd_last) begin
                    rd_col  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
            if (out_hs & out_eob) blk_out_cnt <= blk_out_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dct2d_stream.sv
// Scoreboard bench for dct2d_stream with identity row/column kernels.
// A second instance with a 2-bit block counter shares the stimulus to exercise wrap.
module tb_dct2d_stream;
    localparam int N     = 8;
    localparam int IN_W  = 8;
    localparam int MID_W = 8;
    localparam int OUT_W = 12;
    localparam int CNT_W = 15;

    typedef struct {
        logic [N*OUT_W-1:0] data;
        logic               sof;
        logic               eob;
    } col_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic [N*IN_W-1:0]    in_data = '0;
    logic                 in_ready, k2_dc, out_valid, out_sof, out_eob;
    logic [N*IN_W-1:0]    k1_in;
    logic [N*MID_W-1:0]   k1_out, k2_in;
    logic [N*OUT_W-1:0]   k2_out, out_data;
    logic [CNT_W-1:0]     blk_in_cnt, blk_out_cnt;

    logic                 in_ready2, k2_dc2, out_valid2, out_sof2, out_eob2;
    logic [N*IN_W-1:0]    k1_in2;
    logic [N*MID_W-1:0]   k1_out2, k2_in2;
    logic [N*OUT_W-1:0]   k2_out2, out_data2;
    logic [1:0]           blk_in_cnt2, blk_out_cnt2;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_blocks = 0;
    int   ld_cols = 0;
    int   pop_total = 0;
    int   first_pop = 0;
    int   last_pop = 0;
    bit   pend;
    col_t q[$];
    col_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dct2d_stream #(.N(N), .IN_W(IN_W), .MID_W(MID_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .k1_in(k1_in), .k1_out(k1_out), .k2_in(k2_in), .k2_dc(k2_dc), .k2_out(k2_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eob(out_eob), .blk_in_cnt(blk_in_cnt), .blk_out_cnt(blk_out_cnt)
    );

    dct2d_stream #(.N(N), .IN_W(IN_W), .MID_W(MID_W), .OUT_W(OUT_W), .CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .k1_in(k1_in2), .k1_out(k1_out2), .k2_in(k2_in2), .k2_dc(k2_dc2), .k2_out(k2_out2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_sof(out_sof2), .out_eob(out_eob2), .blk_in_cnt(blk_in_cnt2), .blk_out_cnt(blk_out_cnt2)
    );

    // Identity kernels; the column kernel zero-extends to OUT_W.
    assign k1_out  = k1_in;
    assign k1_out2 = k1_in2;
    always_comb begin
        k2_out  = '0;
        k2_out2 = '0;
        for (int r = 0; r < N; r++) begin
            k2_out[r*OUT_W +: OUT_W]  = OUT_W'(k2_in[r*MID_W +: MID_W]);
            k2_out2[r*OUT_W +: OUT_W] = OUT_W'(k2_in2[r*MID_W +: MID_W]);
        end
    end

    function automatic logic [7:0] val(input int b, input int r, input int c);
        return 8'((8*r + c + 37*b) & 255);
    endfunction

    function automatic logic [N*OUT_W-1:0] exp_col(input int b, input int c);
        logic [N*OUT_W-1:0] d;
        d = '0;
        for (int r = 0; r < N; r++) d[r*OUT_W +: OUT_W] = OUT_W'(val(b, r, c));
        return d;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model of full[rd_bank]: a written block has not yet had all its columns loaded.
    always @(negedge clk) begin
        if (reset) begin
            pend = (wr_blocks * N > ld_cols);
            chk("k2_dc", 128'(k2_dc), 128'(pend && (ld_cols % N == 0)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got column %0h expected none", out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", 128'(out_data), 128'(e.data));
                    chk("out_sof", 128'(out_sof), 128'(e.sof));
                    chk("out_eob", 128'(out_eob), 128'(e.eob));
                    if (pop_total == 0) first_pop = cyc;
                    last_pop = cyc;
                    pop_total++;
                end
            end
            if (pend && (!out_valid || out_ready)) ld_cols++;
        end
    end

    task automatic send_row(input int b, input int r, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        for (int c = 0; c < N; c++) in_data[c*IN_W +: IN_W] = val(b, r, c);
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL row_accept_timeout: block %0d row %0d not accepted, expected accept", b, r);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (r == N - 1) begin
            for (int c = 0; c < N; c++) q.push_back('{exp_col(b, c), c == 0, c == N - 1});
            wr_blocks++;
        end
    endtask

    task automatic send_block(input int b);
        int w;
        for (int r = 0; r < N; r++) send_row(b, r, w);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        chk("drain_queue_size", 128'(q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        wr_blocks = 0;
        ld_cols = 0;
        pop_total = 0;
        reset = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_out_sof"}, 128'(out_sof), 128'(0));
        chk({tag, "_out_eob"}, 128'(out_eob), 128'(0));
        chk({tag, "_out_data"}, 128'(out_data), 128'(0));
        chk({tag, "_blk_in_cnt"}, 128'(blk_in_cnt), 128'(0));
        chk({tag, "_blk_out_cnt"}, 128'(blk_out_cnt), 128'(0));
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [1:0] cnt2_exp [5];
        cnt2_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_reset_state("reset");

        // Single block, latency from last row handshake to first column.
        out_ready = 1'b1;
        send_block(0);
        in_valid = 1'b0;
        chk("latency_t1_valid", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1;
        chk("latency_t2_valid", 128'(out_valid), 128'(1));
        chk("latency_t2_sof", 128'(out_sof), 128'(1));
        wait_drain();
        chk("single_blk_in_cnt", 128'(blk_in_cnt), 128'(1));
        chk("single_blk_out_cnt", 128'(blk_out_cnt), 128'(1));

        // Three back-to-back blocks at full rate.
        do_reset();
        for (int b = 1; b <= 3; b++) begin
            for (int r = 0; r < N; r++) begin
                send_row(b, r, w);
                chk("b2b_in_ready_wait", 128'(w), 128'(0));
            end
        end
        in_valid = 1'b0;
        wait_drain();
        chk("b2b_columns", 128'(pop_total), 128'(24));
        chk("b2b_contiguous", 128'(last_pop - first_pop), 128'(23));
        chk("b2b_blk_in_cnt", 128'(blk_in_cnt), 128'(3));
        chk("b2b_blk_out_cnt", 128'(blk_out_cnt), 128'(3));

        // Output stalled: both banks fill, first column is held.
        do_reset();
        out_ready = 1'b0;
        send_block(4);
        send_block(5);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", 128'(in_ready), 128'(0));
            chk("stall_out_valid", 128'(out_valid), 128'(1));
            chk("stall_out_data", 128'(out_data), 128'(exp_col(4, 0)));
            chk("stall_out_sof", 128'(out_sof), 128'(1));
        end
        out_ready = 1'b1;
        wait_drain();
        chk("stall_columns", 128'(pop_total), 128'(16));
        chk("stall_blk_out_cnt", 128'(blk_out_cnt), 128'(2));

        // Reset in the middle of a block discards it.
        do_reset();
        for (int r = 0; r < 5; r++) send_row(6, r, w);
        do_reset();
        check_reset_state("midblk_reset");
        send_block(7);
        in_valid = 1'b0;
        wait_drain();
        chk("after_reset_columns", 128'(pop_total), 128'(8));
        chk("after_reset_blk_out_cnt", 128'(blk_out_cnt), 128'(1));

        // Counter wrap on the 2-bit instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_block(10 + i);
            in_valid = 1'b0;
            wait_drain();
            chk("wrap_blk_out_cnt2", 128'(blk_out_cnt2), 128'(cnt2_exp[i]));
            chk("wrap_blk_out_cnt", 128'(blk_out_cnt), 128'(i + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
